// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-lane MAC accumulator.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_e;

    // Cycles spent flushing S2/S3 after the last beat of a result.
    localparam int unsigned DRAIN_CYCLES = 2;

    // Extension bit for an operand: copies the MSB in signed mode, zero otherwise.
    function automatic logic ext_msb(input logic msb, input logic is_signed);
        return msb & is_signed;
    endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// One lane multiply: signed (DW+1)x(DW+1) product of mode-extended operands.
module mac_lane_mul #(
    parameter int DW = 8
) (
    input  logic signed [DW:0]     a_x,
    input  logic signed [DW:0]     w_x,
    output logic signed [2*DW+1:0] prod
);

    assign prod = a_x * w_x;

endmodule

// File: rtl/mac_accum_array.sv
// Multi-lane MAC: LANES extended multiplies, an adder tree and a beat-count accumulator.
// Define MAC_ACCUM_SAT_EN for a saturating accumulator with a sticky out_ovf flag.
module mac_accum_array
    import mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int ACCW  = 32,
    parameter int LENW  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LENW-1:0]       cfg_len,
    input  logic                  a_signed,
    input  logic                  w_signed,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       out_q,
    output logic                  out_ovf
);

    localparam int LGL  = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int PW   = 2 * DW + 2;
    localparam int SUMW = PW + LGL;
    localparam int EXTW = ((ACCW > SUMW) ? ACCW : SUMW) + 2;

    localparam logic [LENW-1:0] LEN_ONE    = {{(LENW-1){1'b0}}, 1'b1};
    localparam logic [1:0]      DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    mac_state_e        state_q, state_d;
    logic [LENW-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [LENW-1:0]   cnt_inc_s, len_eff_s;
    logic [1:0]        drain_q, drain_d;
    logic              a_sgn_q, a_sgn_d, w_sgn_q, w_sgn_d;
    logic              in_ready_q, in_ready_d;
    logic              accept_s, first_beat_s, eff_a_sgn_s, eff_w_sgn_s;

    logic signed [DW:0]   a_x_q [LANES];
    logic signed [DW:0]   a_x_d [LANES];
    logic signed [DW:0]   w_x_q [LANES];
    logic signed [DW:0]   w_x_d [LANES];
    logic                 s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
    logic signed [PW-1:0] prod_s [LANES];

    logic signed [SUMW-1:0] sum_s, sum_q, sum_d;
    logic                   s2_valid_q, s2_valid_d, s2_first_q, s2_first_d;

    logic [ACCW-1:0]   acc_q, acc_d;
    logic              acc_ovf_q, acc_ovf_d;

    logic              out_valid_q, out_valid_d;
    logic [ACCW-1:0]   out_q_q, out_q_d;
    logic              out_ovf_q, out_ovf_d;

    assign accept_s     = in_valid & in_ready_q;
    assign first_beat_s = accept_s & (state_q == IDLE);
    // Mode and length come from the live inputs on a first beat, from the latch afterwards.
    assign eff_a_sgn_s  = (state_q == IDLE) ? a_signed : a_sgn_q;
    assign eff_w_sgn_s  = (state_q == IDLE) ? w_signed : w_sgn_q;
    assign len_eff_s    = (cfg_len == {LENW{1'b0}}) ? LEN_ONE : cfg_len;
    assign cnt_inc_s    = cnt_q + LEN_ONE;

    // Result sequencing: beat counting, drain timing and output handshake.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        a_sgn_d = a_sgn_q;
        w_sgn_d = w_sgn_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    len_d   = len_eff_s;
                    a_sgn_d = a_signed;
                    w_sgn_d = w_signed;
                    cnt_d   = LEN_ONE;
                    drain_d = 2'd0;
                    state_d = (len_eff_s == LEN_ONE) ? DRAIN : ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    cnt_d   = cnt_inc_s;
                    drain_d = 2'd0;
                    state_d = (cnt_inc_s == len_q) ? DRAIN : ACCUM;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = HOLD;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    end

    // S1 input: capture mode-extended operands of the accepted beat.
    always_comb begin
        a_x_d      = a_x_q;
        w_x_d      = w_x_q;
        s1_valid_d = accept_s;
        if (accept_s) begin
            s1_first_d = first_beat_s;
            for (int i = 0; i < LANES; i++) begin
                a_x_d[i] = {ext_msb(in_a[i*DW+DW-1], eff_a_sgn_s), in_a[i*DW +: DW]};
                w_x_d[i] = {ext_msb(in_w[i*DW+DW-1], eff_w_sgn_s), in_w[i*DW +: DW]};
            end
        end else begin
            s1_first_d = s1_first_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane_mul #(.DW(DW)) u_mul (
            .a_x  (a_x_q[g]),
            .w_x  (w_x_q[g]),
            .prod (prod_s[g])
        );
    end

    // Lane reduction into S2.
    always_comb begin
        sum_s = {SUMW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + SUMW'(prod_s[i]);
        end
        s2_valid_d = s1_valid_q;
        s2_first_d = s1_first_q;
        sum_d      = s1_valid_q ? sum_s : sum_q;
    end

`ifdef MAC_ACCUM_SAT_EN
    localparam logic signed [EXTW-1:0] SMAX = {{(EXTW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [EXTW-1:0] SMIN = {{(EXTW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};
    localparam logic signed [EXTW-1:0] UMAX = {{(EXTW-ACCW){1'b0}}, {ACCW{1'b1}}};

    logic signed [EXTW-1:0] acc_ext_s, tot_s, sat_s;
    logic                   acc_sgn_s, sat_hit_s;

    // S3 accumulator: add at full width, then clamp to the signed/unsigned ACCW range.
    always_comb begin
        acc_sgn_s = a_sgn_q | w_sgn_q;
        if (s2_first_q) begin
            acc_ext_s = {EXTW{1'b0}};
        end else if (acc_sgn_s) begin
            acc_ext_s = EXTW'($signed(acc_q));
        end else begin
            acc_ext_s = EXTW'(acc_q);
        end
        tot_s     = acc_ext_s + EXTW'(sum_q);
        sat_s     = tot_s;
        sat_hit_s = 1'b0;
        if (acc_sgn_s) begin
            if (tot_s > SMAX) begin
                sat_s     = SMAX;
                sat_hit_s = 1'b1;
            end else if (tot_s < SMIN) begin
                sat_s     = SMIN;
                sat_hit_s = 1'b1;
            end else begin
                sat_s     = tot_s;
            end
        end else begin
            if (tot_s[EXTW-1]) begin
                sat_s     = {EXTW{1'b0}};
                sat_hit_s = 1'b1;
            end else if (tot_s > UMAX) begin
                sat_s     = UMAX;
                sat_hit_s = 1'b1;
            end else begin
                sat_s     = tot_s;
            end
        end
        if (s2_valid_q) begin
            acc_d     = sat_s[ACCW-1:0];
            acc_ovf_d = s2_first_q ? sat_hit_s : (acc_ovf_q | sat_hit_s);
        end else begin
            acc_d     = acc_q;
            acc_ovf_d = acc_ovf_q;
        end
    end
`else
    logic [ACCW-1:0] acc_base_s;

    // S3 accumulator: wraps modulo 2^ACCW; first beat of a result reloads it.
    always_comb begin
        acc_base_s = s2_first_q ? {ACCW{1'b0}} : acc_q;
        acc_d      = s2_valid_q ? (acc_base_s + ACCW'(sum_q)) : acc_q;
        acc_ovf_d  = 1'b0;
    end
`endif

    // Output registers: capture the settled accumulator on the first HOLD cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_ovf_d   = out_ovf_q;
        if (state_q == HOLD) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_q_d     = acc_q;
                out_ovf_d   = acc_ovf_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
            end
        end else if (first_beat_s) begin
            out_ovf_d = 1'b0;
        end else begin
            out_ovf_d = out_ovf_q;
        end
    end

    // State, pipeline and output flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= LEN_ONE;
            cnt_q       <= {LENW{1'b0}};
            drain_q     <= 2'd0;
            a_sgn_q     <= 1'b0;
            w_sgn_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                a_x_q[i] <= '0;
                w_x_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            sum_q       <= {SUMW{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            acc_q       <= {ACCW{1'b0}};
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q_q     <= {ACCW{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            a_sgn_q     <= a_sgn_d;
            w_sgn_q     <= w_sgn_d;
            in_ready_q  <= in_ready_d;
            a_x_q       <= a_x_d;
            w_x_q       <= w_x_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            sum_q       <= sum_d;
            s2_valid_q  <= s2_valid_d;
            s2_first_q  <= s2_first_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accum_array.sv
// Directed bench for mac_accum_array: default instance plus an ACCW=16 instance sharing stimulus.
module tb_mac_accum_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        a_signed, w_signed, in_valid, out_ready;
    logic [31:0] in_a, in_w;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_q;
    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_q16;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

`ifdef MAC_ACCUM_SAT_EN
    localparam logic [31:0] EXP_Q16   = 32'h0000_7FFF;
    localparam logic [31:0] EXP_OVF16 = 32'd1;
`else
    localparam logic [31:0] EXP_Q16   = 32'h0000_FC04;
    localparam logic [31:0] EXP_OVF16 = 32'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_accum_array #(.DW(8), .LANES(4), .ACCW(32), .LENW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .a_signed(a_signed), .w_signed(w_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_ovf(out_ovf)
    );

    mac_accum_array #(.DW(8), .LANES(4), .ACCW(16), .LENW(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .a_signed(a_signed), .w_signed(w_signed),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_w(in_w),
        .out_valid(out_valid16), .out_ready(out_ready), .out_q(out_q16), .out_ovf(out_ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] w);
        int g = 0;
        in_a     = a;
        in_w     = w;
        in_valid = 1'b1;
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("beat_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic wait_result(input string tag);
        int g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd3);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_len = 8'd1;
        a_signed = 1'b0; w_signed = 1'b0; in_a = 32'd0; in_w = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_q", out_q, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Signed, len=1, -128 * -128 on every lane.
        cfg_len = 8'd1; a_signed = 1'b1; w_signed = 1'b1;
        send_beat(32'h8080_8080, 32'h8080_8080);
        in_valid = 1'b0;
        chk("t1_drain_ready", {31'd0, in_ready}, 32'd0);
        wait_result("t1");
        chk("t1_q", out_q, 32'd65536);
        chk("t1_ovf", {31'd0, out_ovf}, 32'd0);
        handshake("t1");
        chk("t1_q_hold", out_q, 32'd65536);

        // Unsigned, len=4, 255*255 with one-cycle gaps.
        cfg_len = 8'd4; a_signed = 1'b0; w_signed = 1'b0;
        for (int b = 0; b < 3; b++) begin
            send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
            in_valid = 1'b0;
            @(negedge clk);
            chk("t2_accum_ready", {31'd0, in_ready}, 32'd1);
        end
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        chk("t2_drain_ready", {31'd0, in_ready}, 32'd0);
        wait_result("t2");
        chk("t2_q", out_q, 32'd1040400);
        chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
        handshake("t2");

        // Mixed: A signed (-1), W unsigned (255).
        cfg_len = 8'd1; a_signed = 1'b1; w_signed = 1'b0;
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        wait_result("t3");
        chk("t3_q", out_q, 32'hFFFF_FC04);
        handshake("t3");

        // Backpressure with the next result's first beat already presented.
        cfg_len = 8'd1; a_signed = 1'b1; w_signed = 1'b1;
        send_beat(32'h0000_0005, 32'h0000_0007);
        in_valid = 1'b0;
        wait_result("t4a");
        chk("t4a_q", out_q, 32'd35);
        cfg_len = 8'd2; in_a = 32'h0003_0000; in_w = 32'h0002_0000; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_bp_q", out_q, 32'd35);
            chk("t4_bp_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_bp_valid", {31'd0, out_valid}, 32'd1);
        end
        handshake("t4a");
        send_beat(32'h0003_0000, 32'h0002_0000);
        send_beat(32'h0003_0000, 32'h0002_0000);
        in_valid = 1'b0;
        wait_result("t4b");
        chk("t4b_q", out_q, 32'd12);
        handshake("t4b");

        // 127*127 per lane: fits ACCW=32, exceeds the signed ACCW=16 range.
        cfg_len = 8'd1; a_signed = 1'b1; w_signed = 1'b1;
        send_beat(32'h7F7F_7F7F, 32'h7F7F_7F7F);
        in_valid = 1'b0;
        wait_result("t5");
        chk("t5_q", out_q, 32'd64516);
        chk("t5_ovf", {31'd0, out_ovf}, 32'd0);
        chk("t5_q16", {16'd0, out_q16}, EXP_Q16);
        chk("t5_ovf16", {31'd0, out_ovf16}, EXP_OVF16);
        handshake("t5");
        chk("t5_ovf16_hold", {31'd0, out_ovf16}, EXP_OVF16);
        send_beat(32'h0000_0002, 32'h0000_0003);
        in_valid = 1'b0;
        chk("t6_ovf16_clear", {31'd0, out_ovf16}, 32'd0);
        wait_result("t6");
        chk("t6_q", out_q, 32'd6);
        chk("t6_q16", {16'd0, out_q16}, 32'd6);
        handshake("t6");

        // Reset mid-ACCUM discards the partial result.
        cfg_len = 8'd4;
        send_beat(32'h0000_0009, 32'h0000_0009);
        in_valid = 1'b0;
        @(negedge clk);
        send_beat(32'h0000_0009, 32'h0000_0009);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t7_rst_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t7_no_valid", {31'd0, out_valid}, 32'd0);
        end
        cfg_len = 8'd1;
        send_beat(32'h0000_0001, 32'h0000_0001);
        in_valid = 1'b0;
        wait_result("t7");
        chk("t7_q", out_q, 32'd1);
        chk("t7_ovf", {31'd0, out_ovf}, 32'd0);
        handshake("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
